uart_rx: RTL and testbench
==========================

# uart_rx

115200 8N1 UART receiver for the PDU serial path; the receive-side counterpart of the PDU transmitter, using the same bit period (218 clocks per bit). It synchronises `uart_rxd` and validates the start bit at mid-bit. It samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each good byte through a hold-until-acknowledged valid/ack handshake. It flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 218, clocks per UART bit; the bit counter runs 0..CLKS_PER_BIT-1.
- `HALF_BIT`, CLKS_PER_BIT/2 (109), clocks from start-bit detect to the start-bit centre check.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  receiver enable; low forces DISABLED synchronously.
- `uart_rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `ack`  in  1  consumer takes `data` when `ack & valid`.
- `data`  out  8  last received good byte.
- `valid`  out  1  high while `data` holds an unconsumed byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a new byte overwrites an unconsumed byte.

## Operation
- **Synchroniser:** 2-FF on `uart_rxd`, both FFs reset to 1. All FSM decisions use the synchronised value `rxd_s`.
- **State encoding:** states DISABLED, WAIT_HIGH, IDLE, START, BITS, STOP. Counter is 10 bits; bit index is 3 bits; an 8-bit shift register holds the byte.
- **Reset (`rst_n` low):** asynchronous.
  - State DISABLED; counter, bit index, shift register and `data` are 0.
  - `valid`, `frame_err` and `overrun` are 0.
- **`en` low (while out of reset):** state DISABLED, counter and bit index 0, `valid` cleared, `data` retained. Any partial frame is discarded with no flags.
- **DISABLED → WAIT_HIGH:** on the next clock with `en` high.
- **WAIT_HIGH → IDLE:** when `rxd_s`==1. This prevents locking onto a frame already in progress or a break condition.
- **IDLE → START:** when `rxd_s`==0; counter is set to 0.
- **START:** counter increments.
  - At counter==HALF_BIT-1, if `rxd_s`==0: go to BITS, counter 0, bit index 0.
  - If `rxd_s`==1 at that point (glitch): go to IDLE with no flags.
- **BITS:**
  - At counter==CLKS_PER_BIT-1: shift register bit[index] ← `rxd_s`, counter is set to 0, index increments.
  - If index was 7, go to STOP.
  - Otherwise counter increments.
- **STOP:** at counter==CLKS_PER_BIT-1, go to IDLE or WAIT_HIGH depending on the stop bit:
  - **`rxd_s`==1 (good byte):** `data` ← shift register, `valid` ← 1, state IDLE.
    - If `valid` was already 1 and `ack` is low this cycle, `overrun` pulses and the old byte is lost.
  - **`rxd_s`==0 (bad stop bit):** `frame_err` pulses, `data` and `valid` are unchanged, state WAIT_HIGH.
- **`valid` clear:** cleared the cycle after `ack & valid`.
  - A new byte committing in the same cycle as an `ack` wins: `valid` stays 1, `data` is new, no `overrun`.
  - `ack` while `valid`==0 is ignored.
- **Illegal state encodings:** go to DISABLED.

## Timing
- **Clock edge numbering:** E0 is the first posedge at which synchroniser FF1 captures `uart_rxd`==0.
  - `rxd_s` is low after E1.
  - IDLE→START at E2.
  - Start centre check at E(2+HALF_BIT) = E111.
  - Data bit k is sampled at E(111+218·(k+1)); each sample reflects the pin 2 cycles earlier, which is the bit centre.
  - The stop bit is sampled at E(2+HALF_BIT+9·CLKS_PER_BIT) = E2073.
- **Latency:** `valid`/`data` update, or `frame_err` pulses, after edge E2073, i.e. 2073 clocks from the start edge.
- **Back-to-back frames:** the return to IDLE happens at the stop-bit centre. That leaves half a bit to detect the next start edge, so back-to-back frames at 115200 are received without loss.
- **Pulses:** `frame_err` and `overrun` are high for exactly one cycle and are never asserted together.
- **Clock tolerance:** ±2% baud mismatch must still sample every bit inside its middle 50%.

## Test plan
- **Single byte:** reset, `en`=1, line high; send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first, 218 clk/bit) → `valid` rises exactly 2073 clocks after the first low sample, `data`=0xA5, `frame_err`=`overrun`=0. Pulse `ack` → `valid`=0 next cycle.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap, acking each byte on `valid` → `data` reads 0x00 then 0xFF, no flags raised.
- **Overrun:** send 0x3C then 0xC3 with no `ack` → after frame 2, `overrun` pulses once, `data`=0xC3, `valid`=1. Repeat with `ack` in the same cycle frame 2 commits → no `overrun`, `valid`=1.
- **Framing error:** send 0x55 with the stop bit low, then hold the line low 1000 clocks, then high → one `frame_err` pulse and `valid` unchanged. No new frame starts until the line returns high; a following 0x12 is received correctly.
- **Glitch rejection:** drive the line low for 40 clocks in IDLE → state returns to IDLE after the half-bit check, no `valid`. Repeat with baud ±2% on 0x96 → `data`=0x96.
- **Disable and reset mid-frame:** drop `en` during bit 4 → `valid`=0, no flags; re-enable with the line high and send 0x81 → received correctly. Assert `rst_n`=0 mid-frame → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit start validation,
// centre sampling of 8 data bits LSB-first, and a held valid/ack output.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 218,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       uart_rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    S_DISABLED  = 3'd0,
    S_WAIT_HIGH = 3'd1,
    S_IDLE      = 3'd2,
    S_START     = 3'd3,
    S_BITS      = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rxd_s;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;

  state_t            w_state_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic [IDX_W-1:0]  w_idx_n;
  logic [BYTE_W-1:0] w_shift_n;
  logic [BYTE_W-1:0] w_data_n;
  logic              w_valid_n;
  logic              w_frame_err_n;
  logic              w_overrun_n;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_DISABLED;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_shift     <= w_shift_n;
      r_data      <= w_data_n;
      r_valid     <= w_valid_n;
      r_frame_err <= w_frame_err_n;
      r_overrun   <= w_overrun_n;
    end
  end

  // Next-state and output logic; a commit in the same cycle as ack wins over the clear.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_idx_n       = r_idx;
    w_shift_n     = r_shift;
    w_data_n      = r_data;
    w_valid_n     = r_valid & ~ack;
    w_frame_err_n = 1'b0;
    w_overrun_n   = 1'b0;

    if (!en) begin
      w_state_n = S_DISABLED;
      w_cnt_n   = '0;
      w_idx_n   = '0;
      w_valid_n = 1'b0;
    end else begin
      case (r_state)
        S_DISABLED: w_state_n = S_WAIT_HIGH;
        S_WAIT_HIGH: begin
          if (w_rxd_s) w_state_n = S_IDLE;
        end
        S_IDLE: begin
          if (!w_rxd_s) begin
            w_state_n = S_START;
            w_cnt_n   = '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            w_cnt_n = '0;
            if (!w_rxd_s) begin
              w_state_n = S_BITS;
              w_idx_n   = '0;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        S_BITS: begin
          if (r_cnt == BIT_LAST) begin
            w_shift_n[r_idx] = w_rxd_s;
            w_cnt_n          = '0;
            w_idx_n          = r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) w_state_n = S_STOP;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            w_cnt_n = '0;
            if (w_rxd_s) begin
              w_data_n    = r_shift;
              w_valid_n   = 1'b1;
              w_overrun_n = r_valid & ~ack;
              w_state_n   = S_IDLE;
            end else begin
              w_frame_err_n = 1'b1;
              w_state_n     = S_WAIT_HIGH;
            end
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_n = S_DISABLED;
          w_cnt_n   = '0;
          w_idx_n   = '0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frames are driven bit-serially on
// the negedge and outputs are compared against hand-computed expectations.
module tb_uart_rx;

  localparam int CPB = 218;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       uart_rxd;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  int   fe_hi = 0, fe_rise = 0, ov_hi = 0, ov_rise = 0, both_cnt = 0;
  logic fe_q = 1'b0, ov_q = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .uart_rxd  (uart_rxd),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Pulse-shape bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) fe_hi++;
    if (frame_err && !fe_q) fe_rise++;
    if (overrun) ov_hi++;
    if (overrun && !ov_q) ov_rise++;
    if (frame_err && overrun) both_cnt++;
    fe_q = frame_err;
    ov_q = overrun;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Caller must be at a negedge; returns at the negedge ending the stop bit.
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (cpb) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      if (valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; uart_rxd = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int fe0, ov0;
    fe0 = fe_rise; ov0 = ov_rise;
    fork
      send_byte(8'hA5, CPB, 1'b1);
      begin
        @(posedge clk);
        repeat (2072) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_early: valid %b at E2072, expected 0", valid); end
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_latency: valid %b at E2073, expected 1", valid); end
        checks++; if (data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", data); end
      end
    join
    checks++; if (fe_rise != fe0 || ov_rise != ov0) begin failures++; $display("FAIL single_flags: fe %0d ov %0d, expected 0 0", fe_rise - fe0, ov_rise - ov0); end
    pulse_ack();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_ack: valid %b expected 0", valid); end
  endtask

  task automatic test_back_to_back();
    int fe0, ov0;
    bit ok;
    fe0 = fe_rise; ov0 = ov_rise;
    fork
      begin
        send_byte(8'h00, CPB, 1'b1);
        send_byte(8'hFF, CPB, 1'b1);
      end
      begin
        wait_valid(3000, ok);
        checks++; if (!ok || data !== 8'h00) begin failures++; $display("FAIL b2b_first: valid %b data %h, expected 1 00", ok, data); end
        pulse_ack();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_ack: valid %b expected 0", valid); end
        wait_valid(3000, ok);
        checks++; if (!ok || data !== 8'hFF) begin failures++; $display("FAIL b2b_second: valid %b data %h, expected 1 ff", ok, data); end
        pulse_ack();
      end
    join
    checks++; if (fe_rise != fe0 || ov_rise != ov0) begin failures++; $display("FAIL b2b_flags: fe %0d ov %0d, expected 0 0", fe_rise - fe0, ov_rise - ov0); end
  endtask

  task automatic test_overrun();
    int fe0, ov0;
    fe0 = fe_rise; ov0 = ov_rise;
    send_byte(8'h3C, CPB, 1'b1);
    send_byte(8'hC3, CPB, 1'b1);
    checks++; if (ov_rise - ov0 != 1) begin failures++; $display("FAIL overrun_count: got %0d expected 1", ov_rise - ov0); end
    checks++; if (data !== 8'hC3 || valid !== 1'b1) begin failures++; $display("FAIL overrun_data: data %h valid %b, expected c3 1", data, valid); end
    checks++; if (fe_rise != fe0) begin failures++; $display("FAIL overrun_fe: got %0d expected 0", fe_rise - fe0); end
    pulse_ack();
    ov0 = ov_rise;
    send_byte(8'h3C, CPB, 1'b1);
    fork
      send_byte(8'hC3, CPB, 1'b1);
      begin
        @(posedge clk);
        repeat (2072) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (valid !== 1'b1 || data !== 8'hC3) begin failures++; $display("FAIL ack_commit: valid %b data %h, expected 1 c3", valid, data); end
      end
    join
    checks++; if (ov_rise != ov0) begin failures++; $display("FAIL ack_commit_overrun: got %0d expected 0", ov_rise - ov0); end
  endtask

  task automatic test_framing();
    int fe0, ov0;
    fe0 = fe_rise; ov0 = ov_rise;
    send_byte(8'h55, CPB, 1'b0);
    repeat (1000) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2500) @(negedge clk);
    checks++; if (fe_rise - fe0 != 1) begin failures++; $display("FAIL frame_count: got %0d expected 1", fe_rise - fe0); end
    checks++; if (valid !== 1'b1 || data !== 8'hC3) begin failures++; $display("FAIL frame_hold: valid %b data %h, expected 1 c3", valid, data); end
    pulse_ack();
    send_byte(8'h12, CPB, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h12) begin failures++; $display("FAIL frame_recover: valid %b data %h, expected 1 12", valid, data); end
    checks++; if (fe_rise - fe0 != 1 || ov_rise != ov0) begin failures++; $display("FAIL frame_flags: fe %0d ov %0d, expected 1 0", fe_rise - fe0, ov_rise - ov0); end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    pulse_ack();
    fe0 = fe_rise; ov0 = ov_rise;
    uart_rxd = 1'b0;
    repeat (40) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (valid !== 1'b0 || fe_rise != fe0) begin failures++; $display("FAIL glitch: valid %b fe %0d, expected 0 0", valid, fe_rise - fe0); end
    send_byte(8'h96, 222, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h96) begin failures++; $display("FAIL baud_fast: valid %b data %h, expected 1 96", valid, data); end
    pulse_ack();
    send_byte(8'h69, 214, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h69) begin failures++; $display("FAIL baud_slow: valid %b data %h, expected 1 69", valid, data); end
    checks++; if (fe_rise != fe0 || ov_rise != ov0) begin failures++; $display("FAIL baud_flags: fe %0d ov %0d, expected 0 0", fe_rise - fe0, ov_rise - ov0); end
  endtask

  task automatic test_disable();
    int fe0, ov0;
    fe0 = fe_rise; ov0 = ov_rise;
    fork
      send_byte(8'hF0, CPB, 1'b1);
      begin
        repeat (CPB * 5 + 100) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || data !== 8'h69) begin failures++; $display("FAIL disable: valid %b data %h, expected 0 69", valid, data); end
      end
    join
    repeat (300) @(negedge clk);
    checks++; if (data !== 8'h69 || fe_rise != fe0 || ov_rise != ov0) begin failures++; $display("FAIL disable_discard: data %h fe %0d ov %0d, expected 69 0 0", data, fe_rise - fe0, ov_rise - ov0); end
    en = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h81, CPB, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h81) begin failures++; $display("FAIL reenable: valid %b data %h, expected 1 81", valid, data); end
  endtask

  task automatic test_async_reset();
    fork
      send_byte(8'h5A, CPB, 1'b1);
      begin
        repeat (600) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (data !== 8'h00 || valid !== 1'b0) begin failures++; $display("FAIL async_reset: data %h valid %b, expected 00 0", data, valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL async_reset_flags: fe %b ov %b, expected 0 0", frame_err, overrun); end
      end
    join
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h3C, CPB, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h3C) begin failures++; $display("FAIL post_reset: valid %b data %h, expected 1 3c", valid, data); end
  endtask

  task automatic test_pulses();
    checks++; if (fe_rise != 1 || fe_hi != fe_rise) begin failures++; $display("FAIL fe_pulse: rises %0d high %0d, expected 1 1", fe_rise, fe_hi); end
    checks++; if (ov_rise != 1 || ov_hi != ov_rise) begin failures++; $display("FAIL ov_pulse: rises %0d high %0d, expected 1 1", ov_rise, ov_hi); end
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL pulse_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_disable();
    test_async_reset();
    test_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
